// File: rtl/decode_regfile_scoreboard_if.sv
// Decode/writeback bundle: issue request, writeback commit, stall and registered operands.
interface decode_regfile_scoreboard_if;
   logic        ISSUE_VALID;
   logic [4:0]  RS1_ADDR;
   logic [4:0]  RS2_ADDR;
   logic        RS1_USED;
   logic        RS2_USED;
   logic [4:0]  RD_ADDR;
   logic        RD_WRITES;
   logic        WB_EN;
   logic [4:0]  WB_ADDR;
   logic [31:0] WB_DATA;
   logic        STALL;
   logic        EX_VALID;
   logic [31:0] RS1_DATA;
   logic [31:0] RS2_DATA;

   modport master (
      output ISSUE_VALID, RS1_ADDR, RS2_ADDR, RS1_USED, RS2_USED,
             RD_ADDR, RD_WRITES, WB_EN, WB_ADDR, WB_DATA,
      input  STALL, EX_VALID, RS1_DATA, RS2_DATA
   );

   modport slave (
      input  ISSUE_VALID, RS1_ADDR, RS2_ADDR, RS1_USED, RS2_USED,
             RD_ADDR, RD_WRITES, WB_EN, WB_ADDR, WB_DATA,
      output STALL, EX_VALID, RS1_DATA, RS2_DATA
   );
endinterface

// File: rtl/decode_regfile_scoreboard.sv
// 32x32 register file with per-register pending-write counters and RAW stall.
// Define RF_WB_BYPASS_EN to forward same-cycle writeback data into the operands.
module decode_regfile_scoreboard #(
   parameter int PEND_W = 2
) (
   input logic                        RF_CLK,
   input logic                        RF_RST_N,
   decode_regfile_scoreboard_if.slave bus
);

`ifdef RF_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic [31:0]       reg_val  [32];
   logic [PEND_W-1:0] pend_val [32];

   logic [PEND_W-1:0] pend_rs1, pend_rs2, pend_rd;
   logic              wb_hit1, wb_hit2;
   logic              hazard1, hazard2, struct_blk;
   logic              stall, issue;
   logic [31:0]       op1, op2;

   logic              ex_valid_q;
   logic [31:0]       rs1_data_q, rs2_data_q;

   always_comb begin
      pend_rs1 = pend_val[bus.RS1_ADDR];
      pend_rs2 = pend_val[bus.RS2_ADDR];
      pend_rd  = pend_val[bus.RD_ADDR];
      wb_hit1  = bus.WB_EN && (bus.WB_ADDR == bus.RS1_ADDR);
      wb_hit2  = bus.WB_EN && (bus.WB_ADDR == bus.RS2_ADDR);

      // A single outstanding write that lands this cycle can be forwarded instead of stalling.
      hazard1 = bus.RS1_USED && (bus.RS1_ADDR != 5'd0) && (pend_rs1 != '0)
                && !(BYPASS && (pend_rs1 == PEND_W'(1)) && wb_hit1);
      hazard2 = bus.RS2_USED && (bus.RS2_ADDR != 5'd0) && (pend_rs2 != '0)
                && !(BYPASS && (pend_rs2 == PEND_W'(1)) && wb_hit2);
      struct_blk = bus.RD_WRITES && (bus.RD_ADDR != 5'd0) && (&pend_rd)
                   && !(bus.WB_EN && (bus.WB_ADDR == bus.RD_ADDR));

      stall = bus.ISSUE_VALID && (hazard1 || hazard2 || struct_blk);
      issue = bus.ISSUE_VALID && !stall;

      op1 = (BYPASS && wb_hit1 && (bus.RS1_ADDR != 5'd0)) ? bus.WB_DATA : reg_val[bus.RS1_ADDR];
      op2 = (BYPASS && wb_hit2 && (bus.RS2_ADDR != 5'd0)) ? bus.WB_DATA : reg_val[bus.RS2_ADDR];
   end

   for (genvar gi = 0; gi < 32; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
         assign reg_val[gi]  = '0;
         assign pend_val[gi] = '0;
      end else begin : g_live
         logic [31:0]       data_q;
         logic [PEND_W-1:0] cnt_q, cnt_d;
         logic              inc, dec;

         assign inc = issue && bus.RD_WRITES && (bus.RD_ADDR == 5'(gi));
         assign dec = bus.WB_EN && (bus.WB_ADDR == 5'(gi));

         // A writeback with nothing outstanding still writes data but leaves the count at zero.
         always_comb begin
            cnt_d = cnt_q;
            if (inc && !dec)
               cnt_d = cnt_q + PEND_W'(1);
            else if (dec && !inc && (cnt_q != '0))
               cnt_d = cnt_q - PEND_W'(1);
         end

         always_ff @(posedge RF_CLK) begin
            if (!RF_RST_N) begin
               data_q <= '0;
               cnt_q  <= '0;
            end else begin
               if (dec)
                  data_q <= bus.WB_DATA;
               cnt_q <= cnt_d;
            end
         end

         assign reg_val[gi]  = data_q;
         assign pend_val[gi] = cnt_q;
      end
   end

   always_ff @(posedge RF_CLK) begin
      if (!RF_RST_N) begin
         ex_valid_q <= 1'b0;
         rs1_data_q <= '0;
         rs2_data_q <= '0;
      end else begin
         ex_valid_q <= issue;
         if (issue) begin
            rs1_data_q <= op1;
            rs2_data_q <= op2;
         end
      end
   end

   assign bus.STALL    = stall;
   assign bus.EX_VALID = ex_valid_q;
   assign bus.RS1_DATA = rs1_data_q;
   assign bus.RS2_DATA = rs2_data_q;

endmodule

// File: tb/tb_decode_regfile_scoreboard.sv
// Self-checking bench: behavioural register-file/pending model feeding an operand scoreboard queue.
module tb_decode_regfile_scoreboard;

`ifdef RF_WB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   decode_regfile_scoreboard_if rf_if ();

   decode_regfile_scoreboard #(.PEND_W(2)) dut (
      .RF_CLK   (clk),
      .RF_RST_N (rst_n),
      .bus      (rf_if)
   );

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
   } exp_t;

   exp_t        sb_q[$];
   logic [31:0] m_rf   [32];
   int          m_pend [32];
   logic [31:0] held1, held2;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_issue = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] opnd(input logic [4:0] a, input bit wbe,
                                        input logic [4:0] wba, input logic [31:0] wbd);
      if (a == 5'd0) return 32'h0;
      if (BYP && wbe && (wba == a)) return wbd;
      return m_rf[a];
   endfunction

   function automatic bit src_hazard(input logic [4:0] a, input bit used, input bit wbe,
                                     input logic [4:0] wba);
      if (!used || a == 5'd0 || m_pend[a] == 0) return 1'b0;
      if (BYP && m_pend[a] == 1 && wbe && wba == a) return 1'b0;
      return 1'b1;
   endfunction

   // One clock of stimulus; called and returning at posedge+1.
   task automatic cycle(input bit rn, input bit iv,
                        input logic [4:0] a1, input bit u1,
                        input logic [4:0] a2, input bit u2,
                        input logic [4:0] rd, input bit rdw,
                        input bit wbe, input logic [4:0] wba, input logic [31:0] wbd);
      bit   st_m, blk, iss;
      exp_t e;
      rst_n                = rn;
      rf_if.ISSUE_VALID    = iv;
      rf_if.RS1_ADDR       = a1;
      rf_if.RS1_USED       = u1;
      rf_if.RS2_ADDR       = a2;
      rf_if.RS2_USED       = u2;
      rf_if.RD_ADDR        = rd;
      rf_if.RD_WRITES      = rdw;
      rf_if.WB_EN          = wbe;
      rf_if.WB_ADDR        = wba;
      rf_if.WB_DATA        = wbd;
      #2;
      blk  = rdw && rd != 5'd0 && m_pend[rd] == 3 && !(wbe && wba == rd);
      st_m = iv && (src_hazard(a1, u1, wbe, wba) || src_hazard(a2, u2, wbe, wba) || blk);
      check_eq("stall", 32'(rf_if.STALL), 32'(st_m));
      iss = rn && iv && !st_m;
      if (iss) begin
         e.a = opnd(a1, wbe, wba, wbd);
         e.b = opnd(a2, wbe, wba, wbd);
         sb_q.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!rn) begin
         for (int r = 0; r < 32; r++) begin
            m_rf[r]   = 32'h0;
            m_pend[r] = 0;
         end
         held1 = 32'h0;
         held2 = 32'h0;
      end else begin
         if (iss && rdw && rd != 5'd0 && !(wbe && wba == rd)) m_pend[rd]++;
         if (wbe && wba != 5'd0) begin
            if (!(iss && rdw && rd == wba) && m_pend[wba] > 0) m_pend[wba]--;
            m_rf[wba] = wbd;
         end
      end
      check_eq("ex_valid", 32'(rf_if.EX_VALID), 32'(iss));
      if (iss) begin
         e = sb_q.pop_front();
         held1 = e.a;
         held2 = e.b;
         n_issue++;
         $display("issue %0d: rs1=x%0d rs2=x%0d -> %h %h", n_issue, a1, a2, rf_if.RS1_DATA, rf_if.RS2_DATA);
      end
      check_eq("rs1_data", rf_if.RS1_DATA, held1);
      check_eq("rs2_data", rf_if.RS2_DATA, held2);
   endtask

   task automatic idle();
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, a, d);
   endtask

   task automatic wr_rd(input logic [4:0] rd);
      cycle(1, 1, 0, 0, 0, 0, rd, 1, 0, 0, 32'h0);
   endtask

   initial begin
      for (int r = 0; r < 32; r++) begin
         m_rf[r]   = 32'h0;
         m_pend[r] = 0;
      end
      held1 = 32'h0;
      held2 = 32'h0;
      @(posedge clk);
      #1;
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);

      // Fresh reads after reset
      cycle(1, 1, 5, 1, 0, 1, 0, 0, 0, 0, 32'h0);
      idle();

      // Write then read
      wb(3, 32'hDEADBEEF);
      cycle(1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 32'h0);

      // RAW on x7, resolved by writeback
      wr_rd(7);
      cycle(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 32'h0);
      cycle(1, 1, 0, 0, 7, 1, 0, 0, 0, 0, 32'h0);
      cycle(1, 1, 0, 0, 7, 1, 0, 0, 1, 7, 32'h00001234);
      cycle(1, 1, 3, 1, 7, 1, 0, 0, 0, 0, 32'h0);
      idle();

      // Saturate pend[9]
      wr_rd(9);
      wr_rd(9);
      wr_rd(9);
      wr_rd(9);
      cycle(1, 1, 0, 0, 0, 0, 9, 1, 1, 9, 32'h0000_0999);
      wr_rd(9);
      cycle(1, 1, 9, 1, 0, 0, 0, 0, 1, 9, 32'h0000_0AAA);
      cycle(1, 1, 9, 1, 0, 0, 0, 0, 1, 9, 32'h0000_0BBB);
      cycle(1, 1, 9, 1, 0, 0, 0, 0, 1, 9, 32'h0000_0CCC);
      cycle(1, 1, 9, 1, 9, 1, 0, 0, 0, 0, 32'h0);

      // x0 is hardwired
      wb(0, 32'hFFFFFFFF);
      cycle(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0);
      wr_rd(0);
      cycle(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 32'h0);

      // Reset discards in-flight tracking
      wb(4, 32'h4444_4444);
      wr_rd(4);
      wr_rd(4);
      cycle(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 32'h0);
      cycle(0, 1, 4, 1, 0, 0, 4, 1, 0, 0, 32'h0);
      cycle(1, 1, 4, 1, 4, 1, 0, 0, 0, 0, 32'h0);

      // Random traffic over a small register window
      for (int i = 0; i < 400; i++) begin
         cycle(1, 1'($urandom_range(0, 3) != 0),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), 32'($urandom));
      end
      idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/decode_regfile_scoreboard.md
Name: decode_regfile_scoreboard

Overview:
- Decode-side end of the writeback interface: holds the 32x32 integer register file that the writeback stage writes.
- Serves two source-operand reads per issued instruction and tracks in-flight destination writes with per-register pending counters.
- Raises a stall while a source register still has a write outstanding.
- Registers operand data into the decode-to-execute boundary, with an optional same-cycle writeback bypass.

Parameters:
- PEND_W, 2, width of each per-register pending counter (max in-flight writes per register = 2^PEND_W - 1).

Ports:
- RF_CLK  input  1  clock; all state updates on posedge.
- RF_RST_N  input  1  synchronous, active-low reset.
- ISSUE_VALID  input  1  decode presents an instruction this cycle.
- RS1_ADDR  input  5  source register 1 address.
- RS2_ADDR  input  5  source register 2 address.
- RS1_USED  input  1  instruction reads RS1.
- RS2_USED  input  1  instruction reads RS2.
- RD_ADDR  input  5  destination register of the issuing instruction.
- RD_WRITES  input  1  issuing instruction writes RD.
- WB_EN  input  1  writeback stage commits a register write this cycle.
- WB_ADDR  input  5  writeback destination.
- WB_DATA  input  32  writeback data (the writeback stage's WD).
- STALL  output  1  combinational; issue blocked this cycle.
- EX_VALID  output  1  registered; operands below belong to a valid issued instruction.
- RS1_DATA  output  32  registered operand 1.
- RS2_DATA  output  32  registered operand 2.

Behaviour:
- Reset (RF_RST_N=0 at posedge):
  - all 31 registers x1..x31 = 0; all pending counters = 0.
  - EX_VALID=0, RS1_DATA=RS2_DATA=0.
  - Reset overrides any simultaneous issue or WB in that cycle; in-flight tracking is discarded.
- x0:
  - reads return 0; WB writes to x0 ignored.
  - never pending, never causes stall; RD_ADDR=0 with RD_WRITES=1 does not increment any counter.
- Issue: issue = ISSUE_VALID & ~STALL.
  - On issue: RS1_DATA/RS2_DATA capture the operand values; EX_VALID<=1.
  - Without issue: EX_VALID<=0; RS1_DATA/RS2_DATA hold their previous values.
  - Latency: operands visible 1 cycle after issue.
- Hazard for source s (RS1 and RS2 independently): s used, addr!=0, pend[addr]!=0. It is not a hazard (bypass case, feature on) when pend[addr]==1 & WB_EN & WB_ADDR==addr.
- Structural block: RD_WRITES & RD_ADDR!=0 & pend[RD_ADDR] at max (all ones). This blocks issue unless WB_EN & WB_ADDR==RD_ADDR in the same cycle.
- STALL = ISSUE_VALID & (hazard1 | hazard2 | structural block). STALL=0 whenever ISSUE_VALID=0.
- Pending counter update per register r (r!=0):
  - inc = issue & RD_WRITES & RD_ADDR==r.
  - dec = WB_EN & WB_ADDR==r.
  - inc&dec: unchanged. inc only: +1. dec only: -1.
  - dec at 0 (spurious WB): counter stays 0, write still performed.
- Register write: WB_EN & WB_ADDR!=0 writes WB_DATA at posedge.
- Operand value: if bypass active & WB_EN & WB_ADDR==addr & addr!=0 then WB_DATA, else the array value (0 for x0).
- RS1 and RS2 may name the same register; both get identical data.

Optional Feature:
- RF_WB_BYPASS_EN.
- Defined: same-cycle WB_DATA forwarding into RS1_DATA/RS2_DATA as above; a pending count of 1 with a matching WB does not stall.
- Undefined:
  - no forwarding; hazard whenever pend[addr]!=0.
  - the instruction issues the cycle after the counter reaches 0 and reads the array.
  - costs one extra stall cycle per RAW dependency; the structural block rule is unchanged.

Test Plan:
- Reset then issue RS1=5, RS2=0 used -> next cycle EX_VALID=1, RS1_DATA=0, RS2_DATA=0, STALL=0 throughout.
- WB_EN=1, WB_ADDR=3, WB_DATA=0xDEADBEEF; next cycle issue RS1=3 -> RS1_DATA=0xDEADBEEF one cycle later.
- Issue RD=7 writes; next cycle issue with RS2=7 used -> STALL=1 while pend[7]=1.
  - The cycle WB_ADDR=7, WB_DATA=0x1234 arrives: with RF_WB_BYPASS_EN, STALL=0 and RS2_DATA=0x1234 next cycle.
  - Without RF_WB_BYPASS_EN, STALL=1 that cycle and issue occurs one cycle later with the same data.
- Issue RD=9 three times (PEND_W=2) -> pend[9]=3; fourth issue with RD=9 -> STALL=1 until a WB to x9 arrives. Simultaneous issue RD=9 and WB to x9 -> count stays 3.
- WB_EN to x0 with 0xFFFFFFFF, then read RS1=0 -> RS1_DATA=0; issue RD=0 never stalls later readers of x0.
- Pend[4]=2, assert RF_RST_N=0 for one cycle with ISSUE_VALID=1 -> EX_VALID=0, all counters 0; afterwards reading x4 gives 0 with no stall.
